data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/riscv_mem_pkg.sv | 35 +++
 rtl/mem_lane_align.sv | 47 ++++
 rtl/data_mem_responder.sv | 166 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings,
// responder FSM states and the byte-lane select helper.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } rsp_state_e;

  localparam int BYTES_PER_WORD = 4;

  // Byte lanes touched by an access of the given size at the given
  // low address bits. Illegal size touches no lane.
  function automatic logic [BYTES_PER_WORD-1:0] lane_select(input mem_size_e size,
                                                            input logic [1:0] addr_lo);
    logic [BYTES_PER_WORD-1:0] lanes;
    lanes = '0;
    case (size)
      SIZE_BYTE: lanes = 4'b0001 << addr_lo;
      SIZE_HALF: lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: lanes = 4'b1111;
      default:   lanes = 4'b0000;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane alignment: extracts and extends load data from a
// memory word, and replicates store data across lanes with byte enables.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  mem_size_e   size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_data_o,
  output logic [3:0]  byte_en_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and half out of the word.
  always_comb begin
    byte_sel = rd_word_i[8*addr_lo_i +: 8];
    half_sel = addr_lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
  end

  // Right-align and extend the load result according to size and signedness.
  always_comb begin
    load_data_o = '0;
    case (size_i)
      SIZE_BYTE: load_data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
      SIZE_HALF: load_data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
      SIZE_WORD: load_data_o = rd_word_i;
      default:   load_data_o = '0;
    endcase
  end

  // Replicate store data into every lane; byte enables pick the real ones.
  always_comb begin
    store_data_o = wdata_i;
    case (size_i)
      SIZE_BYTE: store_data_o = {4{wdata_i[7:0]}};
      SIZE_HALF: store_data_o = {2{wdata_i[15:0]}};
      default:   store_data_o = wdata_i;
    endcase
    byte_en_o = lane_select(size_i, addr_lo_i);
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder in front of a word-wide memory,
// with a programmable number of wait states per access.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_UNSIGNED,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  rsp_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;
  logic        access_en;
  logic        req_err;

  logic        we_q;
  mem_size_e   size_q;
  logic        uns_q;
  logic [1:0]  lo_q;
  logic [AW-1:0] idx_q;
  logic [31:0] wdata_q;
  logic        err_q;

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rd_word_q;

  logic [31:0] load_data;
  logic [31:0] store_data;
  logic [3:0]  byte_en;

  // Classify the incoming request: misaligned, out of range or illegal size.
  always_comb begin
    req_err = 1'b0;
    case (mem_size_e'(REQ_SIZE))
      SIZE_BYTE: req_err = 1'b0;
      SIZE_HALF: req_err = REQ_ADDR[0];
      SIZE_WORD: req_err = |REQ_ADDR[1:0];
      default:   req_err = 1'b1;
    endcase
    if ({2'b00, REQ_ADDR[31:2]} >= 32'(DEPTH_WORDS)) begin
      req_err = 1'b1;
    end
  end

  // Next-state and handshake outputs; the access fires when the wait counter is spent.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    access_en = 1'b0;
    REQ_READY = 1'b0;
    RSP_VALID = 1'b0;
    case (state_q)
      ST_IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) begin
          accept  = 1'b1;
          cnt_d   = WAIT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access_en = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request fields on acceptance; held for the whole transaction.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      we_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      uns_q   <= 1'b0;
      lo_q    <= 2'b00;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= REQ_WE;
      size_q  <= mem_size_e'(REQ_SIZE);
      uns_q   <= REQ_UNSIGNED;
      lo_q    <= REQ_ADDR[1:0];
      idx_q   <= REQ_ADDR[AW+1:2];
      wdata_q <= REQ_WDATA;
      err_q   <= req_err;
    end
  end

  // Memory array: registered read plus byte-lane write, both on the access edge only.
  always_ff @(posedge CLK) begin
    if (access_en) begin
      rd_word_q <= mem_q[idx_q];
      if (we_q && !err_q) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_en[b]) begin
            mem_q[idx_q][8*b +: 8] <= store_data[8*b +: 8];
          end
        end
      end
    end
  end

  mem_lane_align u_align (
    .size_i       (size_q),
    .unsigned_i   (uns_q),
    .addr_lo_i    (lo_q),
    .rd_word_i    (rd_word_q),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_data_o (store_data),
    .byte_en_o    (byte_en)
  );

  // Response payload is only driven while a response is presented; stores and errors read zero.
  always_comb begin
    RSP_RDATA = '0;
    RSP_ERR   = 1'b0;
    if (state_q == ST_RESP) begin
      RSP_ERR = err_q;
      if (!err_q && !we_q) begin
        RSP_RDATA = load_data;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (DEPTH_WORDS=256, WAIT_CYCLES=2).
module tb_data_mem_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic [1:0]  REQ_SIZE;
  logic        REQ_UNSIGNED;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .REQ_VALID    (REQ_VALID),
    .REQ_READY    (REQ_READY),
    .REQ_WE       (REQ_WE),
    .REQ_ADDR     (REQ_ADDR),
    .REQ_WDATA    (REQ_WDATA),
    .REQ_SIZE     (REQ_SIZE),
    .REQ_UNSIGNED (REQ_UNSIGNED),
    .RSP_VALID    (RSP_VALID),
    .RSP_READY    (RSP_READY),
    .RSP_RDATA    (RSP_RDATA),
    .RSP_ERR      (RSP_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Present one request at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns);
    @(negedge CLK);
    check_eq("req_ready_idle", {31'd0, REQ_READY}, 32'd1);
    REQ_VALID    = 1'b1;
    REQ_WE       = we;
    REQ_ADDR     = addr;
    REQ_WDATA    = wdata;
    REQ_SIZE     = size;
    REQ_UNSIGNED = uns;
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID    = 1'b0;
    REQ_WE       = 1'b0;
    REQ_ADDR     = 32'hFFFF_FFFF;
    REQ_WDATA    = 32'h0;
    REQ_SIZE     = 2'b00;
    REQ_UNSIGNED = 1'b0;
  endtask

  // Count edges after acceptance until RSP_VALID is seen (bounded).
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!RSP_VALID && lat < 20) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
  endtask

  task automatic finish_rsp();
    RSP_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RSP_READY = 1'b0;
    check_eq("rsp_valid_drop", {31'd0, RSP_VALID}, 32'd0);
  endtask

  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                      input logic [31:0] exp_data, input logic exp_err);
    int lat;
    issue(we, addr, wdata, size, uns);
    wait_rsp(lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'd3);
    check_eq({tag, "_rdata"}, RSP_RDATA, exp_data);
    check_eq({tag, "_err"}, {31'd0, RSP_ERR}, {31'd0, exp_err});
    $display("xact %-10s we=%0d addr=%08h size=%0d rdata=%08h err=%0d lat=%0d",
             tag, we, addr, size, RSP_RDATA, RSP_ERR, lat);
    finish_rsp();
  endtask

  initial begin
    int lat;
    RST          = 1'b1;
    REQ_VALID    = 1'b0;
    REQ_WE       = 1'b0;
    REQ_ADDR     = 32'h0;
    REQ_WDATA    = 32'h0;
    REQ_SIZE     = 2'b00;
    REQ_UNSIGNED = 1'b0;
    RSP_READY    = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK);
    check_eq("rst_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
    check_eq("rst_rsp_rdata", RSP_RDATA, 32'd0);
    check_eq("rst_rsp_err", {31'd0, RSP_ERR}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    check_eq("rst_req_ready", {31'd0, REQ_READY}, 32'd1);

    // Word store / load and lane extraction
    xact("sw_10",   1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b0);
    xact("lw_10",   1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
    xact("lb_13",   1'b0, 32'h13, 32'h0,        2'b00, 1'b0, 32'hFFFFFFDE, 1'b0);
    xact("lbu_13",  1'b0, 32'h13, 32'h0,        2'b00, 1'b1, 32'h000000DE, 1'b0);
    xact("lh_10",   1'b0, 32'h10, 32'h0,        2'b01, 1'b0, 32'hFFFFBEEF, 1'b0);
    xact("lhu_12",  1'b0, 32'h12, 32'h0,        2'b01, 1'b1, 32'h0000DEAD, 1'b0);

    // Byte store touches one lane only
    xact("sb_11",   1'b1, 32'h11, 32'hAAAAAA55, 2'b00, 1'b0, 32'h0,        1'b0);
    xact("lw_10b",  1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hDEAD55EF, 1'b0);
    xact("lb_11",   1'b0, 32'h11, 32'h0,        2'b00, 1'b0, 32'h00000055, 1'b0);

    // Error cases, then memory unchanged
    xact("lh_11",   1'b0, 32'h11,  32'h0,        2'b01, 1'b0, 32'h0, 1'b1);
    xact("sw_12",   1'b1, 32'h12,  32'hFFFFFFFF, 2'b10, 1'b0, 32'h0, 1'b1);
    xact("lw_400",  1'b0, 32'h400, 32'h0,        2'b10, 1'b0, 32'h0, 1'b1);
    xact("sz11_10", 1'b1, 32'h10,  32'hFFFFFFFF, 2'b11, 1'b0, 32'h0, 1'b1);
    xact("lw_10c",  1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'hDEAD55EF, 1'b0);

    // Back-pressure: response held for 5 cycles, a request presented meanwhile is ignored
    issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    wait_rsp(lat);
    check_eq("hold_lat", 32'(lat), 32'd3);
    REQ_VALID = 1'b1;
    REQ_WE    = 1'b1;
    REQ_ADDR  = 32'h10;
    REQ_WDATA = 32'h0;
    REQ_SIZE  = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      check_eq("hold_valid", {31'd0, RSP_VALID}, 32'd1);
      check_eq("hold_rdata", RSP_RDATA, 32'hDEAD55EF);
      check_eq("hold_req_ready", {31'd0, REQ_READY}, 32'd0);
    end
    $display("xact hold      rdata=%08h valid=%0d held 5 cycles", RSP_RDATA, RSP_VALID);
    REQ_VALID = 1'b0;
    REQ_WE    = 1'b0;
    finish_rsp();
    check_eq("hold_idle_ready", {31'd0, REQ_READY}, 32'd1);
    xact("lw_10d",  1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD55EF, 1'b0);

    // Reset in the middle of a store's wait phase
    xact("sw_20",   1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0, 32'h0, 1'b0);
    issue(1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check_eq("midrst_valid", {31'd0, RSP_VALID}, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check_eq("midrst_req_ready", {31'd0, REQ_READY}, 32'd1);
    repeat (4) @(negedge CLK);
    check_eq("midrst_no_rsp", {31'd0, RSP_VALID}, 32'd0);
    $display("xact midrst    store to 00000020 dropped by reset");
    xact("lw_20",   1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
